// File: rtl/pcileech_com_tx_arb.sv
// Round-robin arbiter and 8-word packer for the upstream com_din path.
// Requesters offer 32-bit words over valid/ready. Accepted words are packed
// into 256-bit beats. A partial beat is padded and flushed after an idle timeout.
module pcileech_com_tx_arb #(
  parameter int          NUM_REQ       = 4,
  parameter int          MAX_BURST     = 16,
  parameter int          FLUSH_TIMEOUT = 32,
  parameter logic [31:0] PAD_WORD      = 32'h66665555
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ*32-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [255:0]            com_din,
  output logic                    com_din_wr_en,
  input  logic                    com_din_ready,
  output logic [2:0]              grant_id,
  output logic [31:0]             stat_beats
);

  localparam logic [9:0] TMO_LAST   = 10'(FLUSH_TIMEOUT - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [2:0] LAST_REQ   = 3'(NUM_REQ - 1);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t        r_state;
  logic [2:0]    r_grant_id;
  logic          r_first;
  logic [7:0]    r_burst;
  logic [3:0]    r_count;
  logic [9:0]    r_tmo;
  logic [31:0]   r_pack [8];
  logic [255:0]  r_com_din;
  logic          r_wr_en;
  logic [31:0]   r_stat_beats;

  logic          w_full;
  logic          w_partial;
  logic          w_beat_wr;
  logic          w_tmo_flush;
  logic          w_gnt_valid;
  logic [31:0]   w_gnt_data;
  logic          w_accept;
  logic          w_burst_last;
  logic [2:0]    w_start;
  logic          w_found;
  logic [2:0]    w_pick;
  logic [255:0]  w_full_beat;
  logic [255:0]  w_pad_beat;
  logic [NUM_REQ-1:0] w_req_ready;

  assign w_full       = (r_count == 4'd8);
  assign w_partial    = (r_count != 4'd0) && !w_full;
  assign w_beat_wr    = w_full && com_din_ready;
  // A timed-out partial beat is written only when the sink can take it.
  assign w_tmo_flush  = w_partial && (r_tmo == TMO_LAST) && com_din_ready;
  assign w_accept     = (r_state == ST_GRANT) && w_gnt_valid && !w_full && !w_tmo_flush;
  assign w_burst_last = (r_burst == BURST_LAST);

  // Select the granted requester's valid/data and drive its ready.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_data  = 32'd0;
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_gnt_valid    = req_valid[i];
        w_gnt_data     = req_data[32*i +: 32];
        w_req_ready[i] = (r_state == ST_GRANT) && !w_full && !w_tmo_flush;
      end else begin
        w_req_ready[i] = 1'b0;
      end
    end
  end

  // Round-robin search: first valid at or after the start index, then wrap below it.
  always_comb begin
    if (r_first) begin
      w_start = 3'd0;
    end else if (r_grant_id == LAST_REQ) begin
      w_start = 3'd0;
    end else begin
      w_start = r_grant_id + 3'd1;
    end
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pick  = (!w_found && req_valid[i] && (3'(i) >= w_start)) ? 3'(i) : w_pick;
      w_found = w_found | (req_valid[i] && (3'(i) >= w_start));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pick  = (!w_found && req_valid[i] && (3'(i) < w_start)) ? 3'(i) : w_pick;
      w_found = w_found | (req_valid[i] && (3'(i) < w_start));
    end
  end

  // Assemble the full beat and the padded beat from the pack registers.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_full_beat[32*k +: 32] = r_pack[k];
      w_pad_beat[32*k +: 32]  = (4'(k) < r_count) ? r_pack[k] : PAD_WORD;
    end
  end

  // Packing, beat writes, idle timeout and beat statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= 4'd0;
      r_tmo        <= 10'd0;
      r_com_din    <= 256'd0;
      r_wr_en      <= 1'b0;
      r_stat_beats <= 32'd0;
      for (int k = 0; k < 8; k++) begin
        r_pack[k] <= 32'd0;
      end
    end else begin
      if (w_beat_wr) begin
        r_com_din    <= w_full_beat;
        r_wr_en      <= 1'b1;
        r_count      <= 4'd0;
        r_stat_beats <= r_stat_beats + 32'd1;
      end else if (w_tmo_flush) begin
        r_com_din    <= w_pad_beat;
        r_wr_en      <= 1'b1;
        r_count      <= 4'd0;
        r_stat_beats <= r_stat_beats + 32'd1;
      end else if (w_accept) begin
        r_pack[r_count[2:0]] <= w_gnt_data;
        r_count              <= r_count + 4'd1;
        r_wr_en              <= 1'b0;
      end else begin
        r_wr_en <= 1'b0;
      end

      if (w_accept || w_beat_wr || w_tmo_flush) begin
        r_tmo <= 10'd0;
      end else if (w_partial && (r_tmo != TMO_LAST)) begin
        r_tmo <= r_tmo + 10'd1;
      end else begin
        r_tmo <= r_tmo;
      end
    end
  end

  // Arbitration state machine: one ARB cycle per tenure, burst-limited GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARB;
      r_grant_id <= 3'd0;
      r_first    <= 1'b1;
      r_burst    <= 8'd0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_burst    <= 8'd0;
            r_first    <= 1'b0;
            r_state    <= ST_GRANT;
          end else begin
            r_state <= ST_ARB;
          end
        end
        ST_GRANT: begin
          if (!w_gnt_valid) begin
            r_state <= ST_ARB;
          end else if (w_accept) begin
            r_burst <= r_burst + 8'd1;
            r_state <= w_burst_last ? ST_ARB : ST_GRANT;
          end else begin
            r_state <= ST_GRANT;
          end
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  assign req_ready     = w_req_ready;
  assign com_din       = r_com_din;
  assign com_din_wr_en = r_wr_en;
  assign grant_id      = r_grant_id;
  assign stat_beats    = r_stat_beats;

endmodule

// File: tb/tb_pcileech_com_tx_arb.sv
// Randomized bench for pcileech_com_tx_arb. A transaction-level model
// (word queue, idle counter, tenure bookkeeping) predicts every output each cycle.
module tb_pcileech_com_tx_arb;

  localparam int          NR   = 4;
  localparam int          MB   = 16;
  localparam int          FT   = 32;
  localparam logic [31:0] PADW = 32'h66665555;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [255:0]   com_din;
  logic           com_din_wr_en;
  logic           com_din_ready;
  logic [2:0]     grant_id;
  logic [31:0]    stat_beats;

  logic [31:0]    d [NR];

  pcileech_com_tx_arb #(
    .NUM_REQ(NR), .MAX_BURST(MB), .FLUSH_TIMEOUT(FT), .PAD_WORD(PADW)
  ) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .com_din(com_din), .com_din_wr_en(com_din_wr_en),
    .com_din_ready(com_din_ready), .grant_id(grant_id), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  // Pack per-requester words onto the flat data bus.
  always_comb begin
    for (int i = 0; i < NR; i++) req_data[32*i +: 32] = d[i];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0]  q[$];
  int           m_idle;
  bit           m_tenure;
  bit           m_first;
  logic [1:0]   m_gid;
  int           m_taken;
  logic [255:0] m_din;
  bit           m_wr;
  logic [31:0]  m_beats;
  int           n_acc, n_pad_beats, n_full_beats;

  task automatic model_reset();
    q.delete();
    m_idle = 0; m_tenure = 0; m_first = 1; m_gid = 2'd0; m_taken = 0;
    m_din = '0; m_wr = 0; m_beats = 32'd0;
  endtask

  function automatic bit m_tflush();
    return (q.size() > 0) && (q.size() < 8) && (m_idle == FT - 1) && com_din_ready;
  endfunction

  function automatic logic [NR-1:0] m_ready();
    logic [NR-1:0] r = '0;
    if (m_tenure && q.size() != 8 && !m_tflush()) r[m_gid] = 1'b1;
    return r;
  endfunction

  // Advance the model across one posedge using the inputs applied this cycle.
  task automatic model_step();
    int  qn   = q.size();
    bit  tf   = m_tflush();
    bit  acc  = m_ready()[m_gid] && req_valid[m_gid];
    logic [31:0] w = d[m_gid];
    logic [1:0] start, c;
    bit found;
    m_wr = 0;
    if (qn == 8 && com_din_ready) begin
      for (int k = 0; k < 8; k++) m_din[32*k +: 32] = q.pop_front();
      m_wr = 1; m_beats = m_beats + 32'd1; n_full_beats++;
    end else if (tf) begin
      for (int k = 0; k < 8; k++) m_din[32*k +: 32] = (k < qn) ? q[k] : PADW;
      q.delete();
      m_wr = 1; m_beats = m_beats + 32'd1; n_pad_beats++;
    end
    if (acc) begin
      q.push_back(w); n_acc++;
    end
    if (acc || m_wr) m_idle = 0;
    else if (qn > 0 && qn < 8 && m_idle < FT - 1) m_idle++;
    if (!m_tenure) begin
      start = m_first ? 2'd0 : m_gid + 2'd1;
      found = 0;
      for (int k = 0; k < NR; k++) begin
        c = start + 2'(k);
        if (!found && req_valid[c]) begin
          found = 1; m_gid = c; m_taken = 0; m_tenure = 1; m_first = 0;
        end
      end
    end else if (!req_valid[m_gid]) begin
      m_tenure = 0;
    end else if (acc) begin
      m_taken++;
      if (m_taken == MB) m_tenure = 0;
    end
  endtask

  int rdy_hold = 0;
  int phase;

  // Choose next-cycle inputs according to the current test phase.
  task automatic drive(input int cyc);
    phase = (cyc < 600) ? 0 : (cyc < 1800) ? 1 : (cyc < 3000) ? 2 : (cyc < 4500) ? 3 : 4;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) d[i] = $urandom;
    case (phase)
      0: begin req_valid = 4'hF; com_din_ready = 1'b1; end
      1: begin
        for (int i = 0; i < NR; i++) req_valid[i] = ($urandom_range(0, 15) == 0);
        com_din_ready = ($urandom_range(0, 9) != 0);
      end
      2, 3: begin
        for (int i = 0; i < NR; i++) req_valid[i] = ($urandom_range(0, 1) == 1);
        if (rdy_hold == 0) begin
          com_din_ready = ($urandom_range(0, 2) != 0);
          rdy_hold = $urandom_range(1, 25);
        end else rdy_hold--;
        if (phase == 3 && $urandom_range(0, 149) == 0) rst = 1'b1;
      end
      default: begin
        req_valid = {($urandom_range(0, 3) != 0), 3'b000};
        com_din_ready = ($urandom_range(0, 4) != 0);
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; com_din_ready = 1'b1;
    for (int i = 0; i < NR; i++) d[i] = 32'd0;
    n_acc = 0; n_pad_beats = 0; n_full_beats = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    drive(0);
    for (int cyc = 1; cyc <= 5500; cyc++) begin
      @(negedge clk);
      chk("req_ready",  req_ready,     m_ready());
      chk("wr_en",      com_din_wr_en, m_wr);
      chk("com_din",    com_din,       m_din);
      chk("grant_id",   grant_id,      {1'b0, m_gid});
      chk("stat_beats", stat_beats,    m_beats);
      if (rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      drive(cyc);
    end
    chk("saw_full_beats",   (n_full_beats > 20), 1'b1);
    chk("saw_padded_beats", (n_pad_beats > 5),   1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
